ember_fetch: RTL and testbench

Instruction fetch stage of the Ember core. Reads 32-bit instruction words from instruction memory over a req/ack handshake, detects the immediate-follows flag (`inst[1]`) and fetches the trailing 64-bit immediate as two 32-bit words. It then hands the instruction word, and optionally the immediate, to the decoder in order, and supports PC redirect from the branch unit.

---
 rtl/ember_fetch.sv | 169 ++++++++++++++++
 tb/tb_ember_fetch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ember_fetch.sv
// Ember instruction fetch: pulls instruction words (plus an optional trailing
// 64-bit immediate) over a req/ack memory port and offers them to the decoder in order.
module ember_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 64,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [DATA_W-1:0] imm,
  output logic              imm_valid,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              dec_ready,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    F_INST, F_IMM_LO, F_IMM_HI, ISSUE_INST, ISSUE_IMM, DRAIN
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n, mem_addr_n, pc_out_n;
  logic                mem_req_n, inst_valid_n, imm_valid_n, has_imm, has_imm_n;
  logic [INST_W-1:0]   inst_n;
  logic [DATA_W-1:0]   imm_n;
  logic                xfer;
  logic [ADDR_W-1:0]   pc_inc, redir_tgt;

  assign xfer      = mem_req & mem_ack;
  assign pc_inc    = pc + ADDR_W'(4);
  assign redir_tgt = redirect_pc & ~ADDR_W'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= F_INST;
      pc         <= RESET_PC;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
      inst       <= '0;
      imm        <= '0;
      inst_valid <= 1'b0;
      imm_valid  <= 1'b0;
      pc_out     <= '0;
      has_imm    <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      mem_req    <= mem_req_n;
      mem_addr   <= mem_addr_n;
      inst       <= inst_n;
      imm        <= imm_n;
      inst_valid <= inst_valid_n;
      imm_valid  <= imm_valid_n;
      pc_out     <= pc_out_n;
      has_imm    <= has_imm_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    mem_req_n    = mem_req;
    mem_addr_n   = mem_addr;
    inst_n       = inst;
    imm_n        = imm;
    inst_valid_n = inst_valid;
    imm_valid_n  = imm_valid;
    pc_out_n     = pc_out;
    has_imm_n    = has_imm;

    case (state)
      F_INST: begin
        if (xfer) begin
          inst_n    = mem_rdata;
          pc_out_n  = pc;
          has_imm_n = mem_rdata[1];
          pc_n      = pc_inc;
          if (mem_rdata[1]) begin
            state_n    = F_IMM_LO;
            mem_addr_n = pc_inc;
          end else begin
            state_n   = ISSUE_INST;
            mem_req_n = 1'b0;
          end
        end else begin
          // also covers the first cycle after reset, when no request is up yet
          mem_req_n  = 1'b1;
          mem_addr_n = pc;
        end
      end
      F_IMM_LO: begin
        if (xfer) begin
          imm_n[INST_W-1:0] = mem_rdata;
          pc_n              = pc_inc;
          mem_addr_n        = pc_inc;
          state_n           = F_IMM_HI;
        end
      end
      F_IMM_HI: begin
        if (xfer) begin
          imm_n[DATA_W-1:INST_W] = mem_rdata;
          pc_n                   = pc_inc;
          mem_req_n              = 1'b0;
          state_n                = ISSUE_INST;
        end
      end
      ISSUE_INST: begin
        if (!inst_valid) begin
          inst_valid_n = 1'b1;
        end else if (dec_ready) begin
          inst_valid_n = 1'b0;
          if (has_imm) begin
            imm_valid_n = 1'b1;
            state_n     = ISSUE_IMM;
          end else begin
            state_n    = F_INST;
            mem_req_n  = 1'b1;
            mem_addr_n = pc;
          end
        end
      end
      ISSUE_IMM: begin
        if (imm_valid && dec_ready) begin
          imm_valid_n = 1'b0;
          state_n     = F_INST;
          mem_req_n   = 1'b1;
          mem_addr_n  = pc;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_n    = F_INST;
          mem_req_n  = 1'b1;
          mem_addr_n = pc;
        end
      end
      default: state_n = F_INST;
    endcase

    // Redirect overrides everything above; any data arriving this edge is dropped.
    if (redirect_en) begin
      pc_n         = redir_tgt;
      inst_valid_n = 1'b0;
      imm_valid_n  = 1'b0;
      inst_n       = inst;
      imm_n        = imm;
      pc_out_n     = pc_out;
      has_imm_n    = has_imm;
      if (mem_req && !mem_ack) begin
        state_n    = DRAIN;
        mem_req_n  = 1'b1;
        mem_addr_n = mem_addr;
      end else begin
        state_n    = F_INST;
        mem_req_n  = 1'b1;
        mem_addr_n = redir_tgt;
      end
    end
  end

endmodule

// File: tb/tb_ember_fetch.sv
// Bench for ember_fetch: directed scenarios plus a randomized run against a
// sequential program-order model with random memory waits and decoder stalls.
module tb_ember_fetch;
  logic        gclk = 1'b0;
  logic        rst;
  logic        mem_req, mem_ack, inst_valid, imm_valid, dec_ready, redirect_en;
  logic [31:0] mem_addr, mem_rdata, inst, pc_out, redirect_pc;
  logic [63:0] imm;

  logic        w_req, w_iv, w_mv;
  logic [31:0] w_addr, w_inst, w_pc_out;
  logic [63:0] w_imm;

  always #5 gclk = ~gclk;

  ember_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk(gclk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .inst(inst), .inst_valid(inst_valid),
    .imm(imm), .imm_valid(imm_valid), .pc_out(pc_out), .dec_ready(dec_ready),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc));

  // zero-wait memory returning plain instructions, always-ready decoder
  ember_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(gclk), .rst(rst), .mem_req(w_req), .mem_addr(w_addr),
    .mem_ack(w_req), .mem_rdata(32'h0000_0001), .inst(w_inst), .inst_valid(w_iv),
    .imm(w_imm), .imm_valid(w_mv), .pc_out(w_pc_out), .dec_ready(1'b1),
    .redirect_en(1'b0), .redirect_pc(32'h0));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  bit [31:0] mem [bit [31:0]];

  function automatic bit [31:0] mem_word(input bit [31:0] a);
    bit [31:0] h;
    if (mem.exists(a)) return mem[a];
    h = (a ^ (a >> 7)) * 32'h2545_F491;
    return h ^ (h >> 13);
  endfunction

  // model state: next instruction address in program order, next fetch address
  bit        model_en = 1'b0;
  bit [31:0] m_pc, m_fa, dw;
  bit        m_pend;
  bit [63:0] m_imm;
  int        n_iss;

  int wait_n = 0;
  int wcnt   = -1;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by the test sequence

  // memory responder
  always @(posedge gclk) begin
    #1;
    if (rst || !mem_req) begin
      mem_ack = 1'b0;
      wcnt    = -1;
    end else begin
      if (wcnt < 0) wcnt = (wait_n < 0) ? int'($urandom_range(2, 0)) : wait_n;
      if (wcnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        wcnt      = -1;
        if (model_en) begin
          chk("fetch_addr", mem_addr, m_fa);
          m_fa += 4;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt--;
      end
    end
    if (!mem_ack) mem_rdata = $urandom;
  end

  // decoder side: ready generation and program-order checking
  logic        p_stall;
  logic [1:0]  p_vv;
  logic [31:0] p_inst;
  logic [63:0] p_imm;

  always @(posedge gclk) begin
    #1;
    if (rdy_mode == 0) dec_ready = 1'b1;
    else if (rdy_mode == 1) dec_ready = ($urandom_range(3, 0) != 0);
    if (model_en) begin
      chk("valid_excl", inst_valid && imm_valid, 1'b0);
      chk("req_during_issue", mem_req && (inst_valid || imm_valid), 1'b0);
      if (p_stall) begin
        chk("hold_vld", {inst_valid, imm_valid}, p_vv);
        chk("hold_inst", inst, p_inst);
        chk("hold_imm", imm, p_imm);
      end
      if (inst_valid && dec_ready) begin
        dw = mem_word(m_pc);
        chk("inst", inst, dw);
        chk("pc_out", pc_out, m_pc);
        chk("inst_before_imm", m_pend, 1'b0);
        n_iss++;
        if (dw[1]) begin
          m_pend = 1'b1;
          m_imm  = {mem_word(m_pc + 8), mem_word(m_pc + 4)};
          m_pc  += 12;
        end else begin
          m_pc += 4;
        end
      end
      if (imm_valid && dec_ready) begin
        chk("imm_expected", m_pend, 1'b1);
        chk("imm", imm, m_imm);
        m_pend = 1'b0;
      end
    end
    p_stall = (inst_valid || imm_valid) && !dec_ready;
    p_vv    = {inst_valid, imm_valid};
    p_inst  = inst;
    p_imm   = imm;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge gclk);
      #2;
    end
  endtask

  task automatic wait_inst(input int lim);
    int k = 0;
    while (!inst_valid && k < lim) begin
      cyc(1);
      k++;
    end
    chk("tmo_inst_valid", inst_valid, 1'b1);
  endtask

  initial begin
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; dec_ready = 1'b0; mem_ack = 1'b0;
    mem[32'h100] = 32'h00A0_0011;
    mem[32'h200] = 32'h0010_0012;
    mem[32'h204] = 32'hDEAD_BEEF;
    mem[32'h208] = 32'h0123_4567;
    mem[32'h400] = 32'h0000_0401;

    // reset values, then a plain instruction with zero-wait memory
    cyc(3);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 32'h100);
    chk("rst_inst", inst, 32'h0);
    chk("rst_imm", imm, 64'h0);
    chk("rst_vld", {inst_valid, imm_valid}, 2'b00);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("w_rst_addr", w_addr, 32'hFFFF_FFFC);
    rst = 1'b0;
    cyc(1);
    chk("p1_req", mem_req, 1'b1);
    chk("p1_addr", mem_addr, 32'h100);
    chk("w_addr0", w_addr, 32'hFFFF_FFFC);
    cyc(1);
    chk("p1_req_off", mem_req, 1'b0);
    chk("p1_no_vld_yet", inst_valid, 1'b0);
    cyc(1);
    chk("p1_vld", inst_valid, 1'b1);
    chk("p1_inst", inst, 32'h00A0_0011);
    chk("p1_pc_out", pc_out, 32'h100);
    chk("w_pc_out", w_pc_out, 32'hFFFF_FFFC);
    cyc(1);
    chk("p1_vld_drop", inst_valid, 1'b0);
    chk("p1_next_req", mem_req, 1'b1);
    chk("p1_next_addr", mem_addr, 32'h104);
    chk("w_wrap_req", w_req, 1'b1);
    chk("w_wrap_addr", w_addr, 32'h0);

    // immediate instruction, reached by a redirect on the first edge
    rst = 1'b1;
    #1;
    chk("rst_async_req", mem_req, 1'b0);
    cyc(2);
    redirect_en = 1'b1; redirect_pc = 32'h200;
    rst = 1'b0;
    cyc(1);
    redirect_en = 1'b0;
    chk("i_addr0", mem_addr, 32'h200);
    chk("i_req0", mem_req, 1'b1);
    cyc(1);
    chk("i_addr_lo", mem_addr, 32'h204);
    cyc(1);
    chk("i_addr_hi", mem_addr, 32'h208);
    chk("i_req_b2b", mem_req, 1'b1);
    cyc(1);
    chk("i_req_off", mem_req, 1'b0);
    cyc(1);
    chk("i_vld", {inst_valid, imm_valid}, 2'b10);
    chk("i_inst", inst, 32'h0010_0012);
    chk("i_pc_out", pc_out, 32'h200);
    cyc(1);
    chk("i_imm_vld", {inst_valid, imm_valid}, 2'b01);
    chk("i_imm", imm, 64'h0123_4567_DEAD_BEEF);
    cyc(1);
    chk("i_imm_drop", imm_valid, 1'b0);
    chk("i_next_addr", mem_addr, 32'h20C);

    // decoder backpressure, then redirect while the next request waits
    rst = 1'b1;
    cyc(2);
    rdy_mode = 2; dec_ready = 1'b0; wait_n = 3;
    rst = 1'b0;
    wait_inst(20);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("bp_vld", inst_valid, 1'b1);
      chk("bp_inst", inst, 32'h00A0_0011);
      chk("bp_no_req", mem_req, 1'b0);
    end
    dec_ready = 1'b1;
    cyc(1);
    dec_ready = 1'b0;
    chk("bp_accept", inst_valid, 1'b0);
    chk("bp_next_addr", mem_addr, 32'h104);
    redirect_en = 1'b1; redirect_pc = 32'h403;
    cyc(1);
    redirect_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_req", mem_req, 1'b1);
      chk("drain_addr", mem_addr, 32'h104);
      cyc(1);
    end
    chk("drain_exit_req", mem_req, 1'b1);
    chk("drain_exit_addr", mem_addr, 32'h400);
    wait_n = 0;
    wait_inst(20);
    chk("drain_inst", inst, 32'h0000_0401);
    chk("drain_pc_out", pc_out, 32'h400);

    // redirect while the immediate is on offer
    rst = 1'b1;
    cyc(2);
    dec_ready = 1'b0;
    redirect_en = 1'b1; redirect_pc = 32'h200;
    rst = 1'b0;
    cyc(1);
    redirect_en = 1'b0;
    wait_inst(20);
    dec_ready = 1'b1;
    cyc(1);
    dec_ready = 1'b0;
    chk("ri_imm_vld", {inst_valid, imm_valid}, 2'b01);
    redirect_en = 1'b1; redirect_pc = 32'h300;
    cyc(1);
    redirect_en = 1'b0;
    chk("ri_imm_drop", imm_valid, 1'b0);
    chk("ri_req", mem_req, 1'b1);
    chk("ri_addr", mem_addr, 32'h300);

    // randomized run against the program-order model
    rst = 1'b1;
    cyc(2);
    rdy_mode = 1; wait_n = -1;
    m_pc = 32'h100; m_fa = 32'h100; m_pend = 1'b0; n_iss = 0;
    model_en = 1'b1;
    rst = 1'b0;
    cyc(3000);
    model_en = 1'b0;
    chk("progress", n_iss > 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end
endmodule
